// File: rtl/duc_pkg.sv
// rtl/duc_pkg.sv - shared addresses, command codes, state encoding and status layout for the DUC scheduler
package duc_pkg;

    localparam logic [13:0] CMD_ADDR_DEF   = 14'd16000;
    localparam logic [13:0] SCHED_ADDR_DEF = 14'd16001;

    localparam logic [31:0] CMD_DL_START = 32'h0000_5555;
    localparam logic [31:0] CMD_DL_END   = 32'h0000_8888;
    localparam logic [31:0] CMD_GO       = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_BUSY     = 3'd3,
        ST_GAP      = 3'd4
    } sched_state_t;

    localparam int CTL_ENABLE = 0;
    localparam int CTL_AUTO   = 1;
    localparam int CTL_SOFT   = 2;
    localparam int CTL_CLR    = 3;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_PEND_LSB  = 4;
    localparam int STAT_DL_OK     = 8;
    localparam int STAT_OVF       = 9;
    localparam int STAT_ACK       = 10;
    localparam int STAT_WDOG      = 11;
    localparam int STAT_BUS       = 12;
    localparam int STAT_CNT_LSB   = 16;

    function automatic logic is_cmd_code(input logic [31:0] d);
        return (d == CMD_DL_START) || (d == CMD_DL_END) || (d == CMD_GO);
    endfunction

endpackage

// File: rtl/duc_tx_sched.sv
// rtl/duc_tx_sched.sv - DUC burst scheduler sharing the local bus with host writes
module duc_tx_sched
    import duc_pkg::*;
#(
    parameter logic [13:0] CMD_ADDR    = CMD_ADDR_DEF,
    parameter logic [13:0] SCHED_ADDR  = SCHED_ADDR_DEF,
    parameter int          ACK_CYCLES  = 8,
    parameter logic [23:0] WDOG_CYCLES = 24'd4000000,
    parameter logic [15:0] GAP_CYCLES  = 16'd256
) (
    input  logic        lbs_clk,
    input  logic        rst_n,
    input  logic        host_we,
    input  logic [13:0] host_addr,
    input  logic [31:0] host_din,
    input  logic        tick_req,
    input  logic [31:0] duc_cmd_register,
    output logic        lbs_we,
    output logic [13:0] lbs_addr,
    output logic [31:0] lbs_din,
    output logic [31:0] sched_status,
    output logic        done_pulse,
    output logic        err_irq
);

    sched_state_t state, state_nxt;

    logic [2:0]  pending;
    logic [23:0] timer;
    logic [15:0] done_cnt;
    logic        enable, auto_mode, dl_active, dl_ok;
    logic        ovf_err, ack_err, wdog_err, bus_err;

    logic        host_sched, host_cmd, host_blocked, host_fwd, sched_we;
    logic        enable_nxt, soft_trig, clr_err;
    logic [1:0]  req_cnt;
    logic [3:0]  pend_sum;
    logic        pend_ovf;
    logic        issue, ack_timeout, wdog_timeout, burst_done;

    // Host always wins the bus; the scheduler only fills idle cycles.
    always_comb begin
        host_sched   = host_we && (host_addr == SCHED_ADDR);
        host_cmd     = host_we && (host_addr == CMD_ADDR);
        host_blocked = host_cmd && is_cmd_code(host_din) &&
                       ((state == ST_ISSUE) || (state == ST_WAIT_ACK) || (state == ST_BUSY));
        host_fwd     = host_we && !host_sched && !host_blocked;
        sched_we     = (state == ST_ISSUE) && !host_we;
        lbs_we       = host_fwd || sched_we;
        lbs_addr     = host_we ? host_addr : (sched_we ? CMD_ADDR : 14'd0);
        lbs_din      = host_we ? host_din  : (sched_we ? CMD_GO   : 32'd0);
    end

    always_comb begin
        enable_nxt = host_sched ? host_din[CTL_ENABLE] : enable;
        soft_trig  = host_sched && host_din[CTL_SOFT];
        clr_err    = host_sched && host_din[CTL_CLR];
        req_cnt    = {1'b0, tick_req & auto_mode} + {1'b0, soft_trig};
        pend_sum   = {1'b0, pending} - {3'b000, issue} + {2'b00, req_cnt};
        pend_ovf   = pend_sum > 4'd7;
    end

    always_comb begin
        state_nxt    = state;
        issue        = 1'b0;
        ack_timeout  = 1'b0;
        wdog_timeout = 1'b0;
        burst_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && (pending != 3'd0) && dl_ok) begin
                    issue     = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!host_we) state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (duc_cmd_register == CMD_GO) begin
                    state_nxt = ST_BUSY;
                end else if (timer == 24'(ACK_CYCLES - 1)) begin
                    ack_timeout = 1'b1;
                    state_nxt   = ST_GAP;
                end
            end
            ST_BUSY: begin
                if (duc_cmd_register == 32'd0) begin
                    burst_done = 1'b1;
                    state_nxt  = ST_GAP;
                end else if (timer == WDOG_CYCLES - 24'd1) begin
                    wdog_timeout = 1'b1;
                    state_nxt    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer == {8'd0, GAP_CYCLES} - 24'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge lbs_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            pending    <= '0;
            enable     <= 1'b0;
            auto_mode  <= 1'b0;
            dl_active  <= 1'b0;
            dl_ok      <= 1'b0;
            ovf_err    <= 1'b0;
            ack_err    <= 1'b0;
            wdog_err   <= 1'b0;
            bus_err    <= 1'b0;
            done_cnt   <= '0;
            done_pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= (state_nxt != state) ? 24'd0 : timer + 24'd1;

            if (host_sched) begin
                enable    <= host_din[CTL_ENABLE];
                auto_mode <= host_din[CTL_AUTO];
            end

            // Requests beyond 7 are dropped; disabling flushes the queue.
            if (!enable_nxt) pending <= '0;
            else if (pend_ovf) pending <= 3'd7;
            else pending <= pend_sum[2:0];

            if (host_cmd && host_fwd) begin
                if (host_din == CMD_DL_START) begin
                    dl_active <= 1'b1;
                    dl_ok     <= 1'b0;
                end else if ((host_din == CMD_DL_END) && dl_active) begin
                    dl_ok     <= 1'b1;
                    dl_active <= 1'b0;
                end
            end

            ovf_err  <= (ovf_err  & ~clr_err) | (enable_nxt & pend_ovf);
            ack_err  <= (ack_err  & ~clr_err) | ack_timeout;
            wdog_err <= (wdog_err & ~clr_err) | wdog_timeout;
            bus_err  <= (bus_err  & ~clr_err) | host_blocked;

            done_pulse <= burst_done;
            done_cnt   <= done_cnt + {15'd0, burst_done};
        end
    end

    always_comb begin
        sched_status                         = '0;
        sched_status[STAT_STATE_LSB +: 3]    = state;
        sched_status[STAT_PEND_LSB +: 3]     = pending;
        sched_status[STAT_DL_OK]             = dl_ok;
        sched_status[STAT_OVF]               = ovf_err;
        sched_status[STAT_ACK]               = ack_err;
        sched_status[STAT_WDOG]              = wdog_err;
        sched_status[STAT_BUS]               = bus_err;
        sched_status[STAT_CNT_LSB +: 16]     = done_cnt;
        err_irq = ovf_err | ack_err | wdog_err | bus_err;
    end

endmodule

// File: tb/tb_duc_tx_sched.sv
// tb/tb_duc_tx_sched.sv - directed scoreboard bench for duc_tx_sched
module tb_duc_tx_sched;

    localparam logic [13:0] CMD = 14'd16000;
    localparam logic [13:0] SCH = 14'd16001;
    localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WACK = 3'd2, S_BUSY = 3'd3, S_GAP = 3'd4;

    logic        lbs_clk = 1'b0;
    logic        rst_n, host_we, tick_req;
    logic [13:0] host_addr;
    logic [31:0] host_din, duc_cmd_register;
    logic        lbs_we, done_pulse, err_irq;
    logic [13:0] lbs_addr;
    logic [31:0] lbs_din, sched_status;

    logic        echo_en, clear_en, duc_zero;
    logic        duc_run;
    int          duc_t;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int rd_idx = 0;
    int n;
    logic [31:0] d;
    logic [45:0] exp_q[$];
    logic [45:0] obs_q[$];
    logic [45:0] e;

    duc_tx_sched #(
        .WDOG_CYCLES(24'd3000),
        .GAP_CYCLES (16'd32)
    ) dut (
        .lbs_clk         (lbs_clk),
        .rst_n           (rst_n),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_din        (host_din),
        .tick_req        (tick_req),
        .duc_cmd_register(duc_cmd_register),
        .lbs_we          (lbs_we),
        .lbs_addr        (lbs_addr),
        .lbs_din         (lbs_din),
        .sched_status    (sched_status),
        .done_pulse      (done_pulse),
        .err_irq         (err_irq)
    );

    always #5 lbs_clk = ~lbs_clk;

    // DUC model: echoes the go command 2 cycles after it lands, clears ~1000 cycles later.
    always @(posedge lbs_clk) begin
        if (duc_zero) begin
            duc_run          <= 1'b0;
            duc_cmd_register <= 32'd0;
        end else if (lbs_we && lbs_addr == CMD && lbs_din == 32'h0000_FFFF) begin
            duc_run <= 1'b1;
            duc_t   <= 0;
        end else if (duc_run) begin
            duc_t <= duc_t + 1;
            if (echo_en && duc_t == 1) duc_cmd_register <= 32'h0000_FFFF;
            if (clear_en && duc_t == 1001) begin
                duc_cmd_register <= 32'd0;
                duc_run          <= 1'b0;
            end
        end
    end

    always @(negedge lbs_clk) begin
        if (lbs_we === 1'b1) obs_q.push_back({lbs_addr, lbs_din});
        if (done_pulse === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge lbs_clk);
        #1;
    endtask

    task automatic host_wr(input logic [13:0] a, input logic [31:0] v, input logic fwd);
        host_we = 1'b1; host_addr = a; host_din = v;
        if (fwd) exp_q.push_back({a, v});
        #1;
        chk("host_wr_lbs_we", lbs_we, fwd);
        tick();
        host_we = 1'b0; host_addr = '0; host_din = '0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int bound, input string tag);
        int k = 0;
        while (sched_status[2:0] !== st && k < bound) begin
            tick();
            k++;
        end
        chk(tag, sched_status[2:0], st);
    endtask

    task automatic dwell(input logic [2:0] st, input int bound, output int k);
        k = 0;
        while (sched_status[2:0] === st && k < bound) begin
            tick();
            k++;
        end
    endtask

    task automatic drain();
        while (rd_idx < obs_q.size()) begin
            chk("sb_have_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_write", obs_q[rd_idx], e);
            end
            rd_idx++;
        end
    endtask

    initial begin
        rst_n = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0; tick_req = 1'b0;
        echo_en = 1'b0; clear_en = 1'b0; duc_zero = 1'b1;
        tick();

        // reset values and combinational passthrough while in reset
        host_we = 1'b1; host_addr = 14'd5; host_din = 32'h1234_5678;
        exp_q.push_back({14'd5, 32'h1234_5678});
        #1;
        chk("rst_status", sched_status, 32'd0);
        chk("rst_done", done_pulse, 1'b0);
        chk("rst_irq", err_irq, 1'b0);
        chk("rst_pass_we", lbs_we, 1'b1);
        chk("rst_pass_din", lbs_din, 32'h1234_5678);
        tick();
        host_we = 1'b0; host_addr = '0; host_din = '0;
        tick();
        rst_n = 1'b1; duc_zero = 1'b0;
        tick();

        // nominal burst
        host_wr(SCH, 32'h1, 1'b0);
        host_wr(CMD, 32'h5555, 1'b1);
        host_wr(CMD, 32'h8888, 1'b1);
        chk("nom_dl_ok", sched_status[8], 1'b1);
        echo_en = 1'b1; clear_en = 1'b1;
        exp_q.push_back({CMD, 32'h0000_FFFF});
        host_wr(SCH, 32'h5, 1'b0);
        chk("nom_pending", sched_status[6:4], 3'd1);
        tick();
        chk("nom_issue", sched_status[2:0], S_ISSUE);
        tick();
        chk("nom_wait_ack", sched_status[2:0], S_WACK);
        wait_state(S_BUSY, 20, "nom_busy");
        wait_state(S_GAP, 1100, "nom_gap");
        dwell(S_GAP, 100, n);
        chk("nom_gap_len", n, 32);
        chk("nom_idle", sched_status[2:0], S_IDLE);
        chk("nom_done_cnt", done_cnt, 1);
        chk("nom_burst_cnt", sched_status[31:16], 16'd1);
        chk("nom_pending0", sched_status[6:4], 3'd0);
        drain();

        // host holds the bus through ISSUE
        host_wr(SCH, 32'h5, 1'b0);
        tick();
        chk("col_issue", sched_status[2:0], S_ISSUE);
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            host_we = 1'b1; host_addr = 14'(100 + i); host_din = d;
            exp_q.push_back({14'(100 + i), d});
            #1;
            chk("col_host_din", lbs_din, d);
            chk("col_host_addr", lbs_addr, 14'(100 + i));
            tick();
            chk("col_still_issue", sched_status[2:0], S_ISSUE);
        end
        host_we = 1'b0; host_addr = '0; host_din = '0;
        exp_q.push_back({CMD, 32'h0000_FFFF});
        #1;
        chk("col_sched_we", lbs_we, 1'b1);
        chk("col_sched_din", lbs_din, 32'h0000_FFFF);
        tick();
        chk("col_wait_ack", sched_status[2:0], S_WACK);
        wait_state(S_GAP, 1200, "col_gap");
        wait_state(S_IDLE, 40, "col_idle");
        chk("col_burst_cnt", sched_status[31:16], 16'd2);
        drain();

        // request overflow with downloads not ready
        host_wr(SCH, 32'h3, 1'b0);
        host_wr(CMD, 32'h5555, 1'b1);
        chk("ovf_dl_ok0", sched_status[8], 1'b0);
        tick_req = 1'b1;
        host_wr(SCH, 32'h7, 1'b0);
        tick_req = 1'b0;
        chk("ovf_add2", sched_status[6:4], 3'd2);
        for (int i = 0; i < 9; i++) begin
            tick_req = 1'b1; tick();
            tick_req = 1'b0; tick();
            if (i == 4) begin
                chk("ovf_at7_pending", sched_status[6:4], 3'd7);
                chk("ovf_at7_noerr", sched_status[9], 1'b0);
            end
        end
        chk("ovf_pending", sched_status[6:4], 3'd7);
        chk("ovf_err", sched_status[9], 1'b1);
        chk("ovf_irq", err_irq, 1'b1);
        tick_req = 1'b1;
        host_wr(SCH, 32'hB, 1'b0);
        tick_req = 1'b0;
        chk("clr_race_ovf", sched_status[9], 1'b1);
        host_wr(SCH, 32'hB, 1'b0);
        chk("clr_ovf", sched_status[9], 1'b0);
        chk("clr_irq", err_irq, 1'b0);
        host_wr(SCH, 32'h0, 1'b0);
        chk("dis_pending", sched_status[6:4], 3'd0);
        host_wr(CMD, 32'h8888, 1'b1);
        chk("ovf_dl_ok1", sched_status[8], 1'b1);
        drain();

        // ack timeout
        echo_en = 1'b0; clear_en = 1'b0;
        exp_q.push_back({CMD, 32'h0000_FFFF});
        host_wr(SCH, 32'h5, 1'b0);
        tick();
        chk("ack_issue", sched_status[2:0], S_ISSUE);
        tick();
        dwell(S_WACK, 20, n);
        chk("ack_wait_len", n, 8);
        chk("ack_gap", sched_status[2:0], S_GAP);
        chk("ack_err", sched_status[10], 1'b1);
        dwell(S_GAP, 100, n);
        chk("ack_gap_len", n, 32);
        chk("ack_idle", sched_status[2:0], S_IDLE);
        drain();

        // watchdog timeout
        host_wr(SCH, 32'h9, 1'b0);
        chk("wd_ack_cleared", sched_status[10], 1'b0);
        echo_en = 1'b1;
        exp_q.push_back({CMD, 32'h0000_FFFF});
        host_wr(SCH, 32'h5, 1'b0);
        wait_state(S_BUSY, 20, "wd_busy");
        dwell(S_BUSY, 3100, n);
        chk("wd_busy_len", n, 3000);
        chk("wd_err", sched_status[11], 1'b1);
        chk("wd_gap", sched_status[2:0], S_GAP);
        dwell(S_GAP, 100, n);
        chk("wd_gap_len", n, 32);
        chk("wd_no_done", done_cnt, 2);
        drain();

        // blocked command write during BUSY, then reset mid-burst
        duc_zero = 1'b1; tick(); duc_zero = 1'b0;
        clear_en = 1'b1;
        host_wr(SCH, 32'h9, 1'b0);
        exp_q.push_back({CMD, 32'h0000_FFFF});
        host_wr(SCH, 32'h5, 1'b0);
        wait_state(S_BUSY, 20, "blk_busy");
        host_wr(CMD, 32'h5555, 1'b0);
        chk("blk_bus_err", sched_status[12], 1'b1);
        chk("blk_irq", err_irq, 1'b1);
        chk("blk_dl_ok_kept", sched_status[8], 1'b1);
        host_wr(14'd200, 32'h5555, 1'b1);
        chk("blk_still_busy", sched_status[2:0], S_BUSY);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_status", sched_status, 32'd0);
        chk("mid_rst_lbs_we", lbs_we, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (1100) tick();
        chk("mid_rst_no_done", done_cnt, 2);
        chk("mid_rst_idle", sched_status[2:0], S_IDLE);
        drain();
        chk("sb_all_consumed", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
